// File: rtl/ntt_bfly_sched.sv
// Butterfly scheduler for one in-place NTT/INTT pass: walks stages and butterflies,
// issues (a, b, twiddle) over valid/ready and holds each stage until write-backs drain.
module ntt_bfly_sched #(
  parameter  int LOG_N   = 8,
  parameter  int MAX_OUT = 4,
  localparam int SW      = $clog2(LOG_N) + 1,
  localparam int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             iss_vld,
  input  logic             iss_rdy,
  output logic [LOG_N-1:0] iss_addr_a,
  output logic [LOG_N-1:0] iss_addr_b,
  output logic [LOG_N-1:0] iss_tw,
  output logic [SW-1:0]    iss_stage,
  output logic             iss_inv,
  output logic             iss_lst,
  input  logic             cmp_vld
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [LOG_N-2:0] i_q, i_d;
  logic [OW-1:0]    o_q, o_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;

  logic             xfer, last_i, last_s, err_set;
  logic [SW-1:0]    l;
  logic [LOG_N-1:0] i_ext, k, a, b, tw;
  logic             unused_mode;

  assign unused_mode = |mode[7:1];

  assign iss_vld = (state_q == ISSUE) && (o_q < OW'(MAX_OUT));
  assign xfer    = iss_vld && iss_rdy && !abort;
  assign last_i  = &i_q;
  assign last_s  = (s_q == SW'(LOG_N - 1));
  assign err_set = cmp_vld && !xfer && (o_q == '0);

  // l = log2(len); both directions share the twiddle base 1 << (LOG_N-1-l)
  always_comb begin
    l     = inv_q ? s_q : SW'(LOG_N - 1) - s_q;
    i_ext = {1'b0, i_q};
    k     = i_ext >> l;
    a     = ((k << l) << 1) | (i_ext & ((LOG_N'(1) << l) - LOG_N'(1)));
    b     = a | (LOG_N'(1) << l);
    tw    = (LOG_N'(1) << (SW'(LOG_N - 1) - l)) + k;
  end

  assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign done       = (state_q == FINISH);
  assign err        = err_q;
  assign iss_addr_a = busy ? a  : '0;
  assign iss_addr_b = busy ? b  : '0;
  assign iss_tw     = busy ? tw : '0;
  assign iss_stage  = s_q;
  assign iss_inv    = inv_q;
  assign iss_lst    = (state_q == ISSUE) && last_i;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    i_d     = i_q;
    o_d     = o_q;
    inv_d   = inv_q;
    err_d   = err_q;
    if (err_set) err_d = 1'b1;
    if (abort) begin
      state_d = IDLE;
      o_d     = '0;
    end else begin
      if (xfer && !cmp_vld)                o_d = o_q + OW'(1);
      else if (!xfer && cmp_vld && !err_set) o_d = o_q - OW'(1);
      case (state_q)
        IDLE: if (start) begin
          inv_d   = mode[0];
          s_d     = '0;
          i_d     = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
        ISSUE: if (xfer) begin
          i_d = i_q + 1'b1;
          if (last_i) begin
            i_d     = '0;
            state_d = DRAIN;
          end
        end
        // the next stage reads what this one writes, so wait for every write-back
        DRAIN: if (o_d == '0) begin
          if (last_s) state_d = FINISH;
          else begin
            s_d     = s_q + SW'(1);
            state_d = ISSUE;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s_q     <= '0;
      i_q     <= '0;
      o_q     <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      i_q     <= i_d;
      o_q     <= o_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_bfly_sched.sv
// Directed bench for ntt_bfly_sched at N=8: table-driven issue streams plus
// hand-written abort, error and outstanding-limit sequences.
module tb_ntt_bfly_sched;
  localparam int LN = 3;
  localparam int SW = $clog2(LN) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start = 0, abort = 0, iss_rdy = 1, cmp_vld = 0;
  logic [7:0]    mode = '0;
  logic          busy, done, err, iss_vld, iss_inv, iss_lst;
  logic [LN-1:0] iss_addr_a, iss_addr_b, iss_tw;
  logic [SW-1:0] iss_stage;

  logic          start2 = 0, abort2 = 0, rdy2 = 1, cmp2 = 0;
  logic [7:0]    mode2 = '0;
  logic          busy2, done2, err2, vld2, inv2, lst2;
  logic [LN-1:0] a2, b2, tw2;
  logic [SW-1:0] stg2;

  ntt_bfly_sched #(.LOG_N(LN), .MAX_OUT(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
    .busy(busy), .done(done), .err(err), .iss_vld(iss_vld), .iss_rdy(iss_rdy),
    .iss_addr_a(iss_addr_a), .iss_addr_b(iss_addr_b), .iss_tw(iss_tw),
    .iss_stage(iss_stage), .iss_inv(iss_inv), .iss_lst(iss_lst), .cmp_vld(cmp_vld)
  );

  ntt_bfly_sched #(.LOG_N(LN), .MAX_OUT(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(abort2), .mode(mode2),
    .busy(busy2), .done(done2), .err(err2), .iss_vld(vld2), .iss_rdy(rdy2),
    .iss_addr_a(a2), .iss_addr_b(b2), .iss_tw(tw2),
    .iss_stage(stg2), .iss_inv(inv2), .iss_lst(lst2), .cmp_vld(cmp2)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
    logic [2:0] stg;
    logic       lst;
  } vec_t;

  vec_t fwd_tbl[12];
  vec_t inv_tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt2  = 0;

  function automatic vec_t mkv(input int a, input int b, input int tw, input int s, input int l);
    vec_t v;
    v.a = 3'(a); v.b = 3'(b); v.tw = 3'(tw); v.stg = 3'(s); v.lst = 1'(l);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic inv);
    mode    = {7'b1010110, inv};
    start   = 1'b1;
    cmp_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // cmp_vld returns two cycles after each transfer
  task automatic run_stream(input logic inv, input bit rnd, input bit poke);
    int         idx = 0, ndone = 0, post = 0, cyc = 0;
    logic       d1 = 0, d2 = 0, xfer, hold = 0;
    logic [9:0] held = '0;
    bit         seen = 0;
    vec_t       e;
    apply_stimulus(inv);
    check_output("start_err_clr", 32'(err), 32'd0);
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_inv", 32'(iss_inv), 32'(inv));
    while (cyc < 400 && post < 3) begin
      start = poke && (cyc == 5);
      if (poke && cyc == 5) mode[0] = ~mode[0];
      iss_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cmp_vld = d2;
      d2 = d1;
      #1;
      xfer = iss_vld && iss_rdy;
      if (hold)
        check_output("hold", 32'({iss_vld, iss_addr_a, iss_addr_b, iss_tw, iss_lst}), 32'({1'b1, held}));
      if (xfer) begin
        if (idx < 12) begin
          e = inv ? inv_tbl[idx] : fwd_tbl[idx];
          check_output($sformatf("iss%0d", idx),
                       32'({iss_addr_a, iss_addr_b, iss_tw, iss_stage, iss_lst}),
                       32'({e.a, e.b, e.tw, e.stg, e.lst}));
        end
        idx++;
      end
      hold = iss_vld && !iss_rdy;
      held = {iss_addr_a, iss_addr_b, iss_tw, iss_lst};
      if (done) begin
        ndone++;
        seen = 1;
      end else if (seen) post++;
      d1 = xfer;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start = 0; cmp_vld = 0; iss_rdy = 1;
    #1;
    check_output("issue_count", 32'(idx), 32'd12);
    check_output("done_once", 32'(ndone), 32'd1);
    check_output("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic cyc2(input logic c);
    cmp2 = c;
    #1;
    if (vld2 && rdy2) cnt2++;
    @(posedge clk); @(negedge clk);
    cmp2 = 1'b0;
  endtask

  initial begin
    int   idx, cyc, ndone;
    logic d1, d2, xfer;
    vec_t e;

    fwd_tbl[0]  = mkv(0,4,1,0,0); fwd_tbl[1]  = mkv(1,5,1,0,0);
    fwd_tbl[2]  = mkv(2,6,1,0,0); fwd_tbl[3]  = mkv(3,7,1,0,1);
    fwd_tbl[4]  = mkv(0,2,2,1,0); fwd_tbl[5]  = mkv(1,3,2,1,0);
    fwd_tbl[6]  = mkv(4,6,3,1,0); fwd_tbl[7]  = mkv(5,7,3,1,1);
    fwd_tbl[8]  = mkv(0,1,4,2,0); fwd_tbl[9]  = mkv(2,3,5,2,0);
    fwd_tbl[10] = mkv(4,5,6,2,0); fwd_tbl[11] = mkv(6,7,7,2,1);
    inv_tbl[0]  = mkv(0,1,4,0,0); inv_tbl[1]  = mkv(2,3,5,0,0);
    inv_tbl[2]  = mkv(4,5,6,0,0); inv_tbl[3]  = mkv(6,7,7,0,1);
    inv_tbl[4]  = mkv(0,2,2,1,0); inv_tbl[5]  = mkv(1,3,2,1,0);
    inv_tbl[6]  = mkv(4,6,3,1,0); inv_tbl[7]  = mkv(5,7,3,1,1);
    inv_tbl[8]  = mkv(0,4,1,2,0); inv_tbl[9]  = mkv(1,5,1,2,0);
    inv_tbl[10] = mkv(2,6,1,2,0); inv_tbl[11] = mkv(3,7,1,2,1);

    repeat (3) @(negedge clk);
    #1;
    check_output("rst_ctrl", 32'({busy, done, err, iss_vld, iss_lst, iss_inv}), 32'd0);
    check_output("rst_addr", 32'({iss_addr_a, iss_addr_b, iss_tw, iss_stage}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check_output("post_rst_idle", 32'({busy, iss_vld, err}), 32'd0);

    $display("[TB] forward stream");
    run_stream(1'b0, 1'b0, 1'b0);

    $display("[TB] completion while idle");
    cmp_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp_vld = 1'b0;
    #1;
    check_output("idle_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check_output("idle_err_sticky", 32'(err), 32'd1);

    $display("[TB] inverse stream with start and mode pokes");
    run_stream(1'b1, 1'b0, 1'b1);

    $display("[TB] forward stream with backpressure");
    run_stream(1'b0, 1'b1, 1'b0);

    $display("[TB] abort in stage 1");
    apply_stimulus(1'b0);
    idx = 0; cyc = 0; d1 = 0; d2 = 0;
    while (idx < 6 && cyc < 100) begin
      cmp_vld = d2;
      d2 = d1;
      #1;
      xfer = iss_vld && iss_rdy;
      if (xfer) begin
        e = fwd_tbl[idx];
        check_output($sformatf("abt_iss%0d", idx),
                     32'({iss_addr_a, iss_addr_b, iss_tw, iss_stage}),
                     32'({e.a, e.b, e.tw, e.stg}));
        idx++;
      end
      d1 = xfer;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check_output("abort_reach", 32'(idx), 32'd6);
    abort = 1'b1;
    cmp_vld = 1'b0;
    #1;
    check_output("abort_hs_vld", 32'(iss_vld), 32'd1);
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    #1;
    check_output("abort_idle", 32'({busy, iss_vld, done}), 32'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    check_output("abort_no_done", 32'(ndone), 32'd0);
    check_output("abort_err_kept", 32'(err), 32'd0);
    cmp_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp_vld = 1'b0;
    #1;
    check_output("abort_o_zero", 32'(err), 32'd1);
    run_stream(1'b0, 1'b0, 1'b0);

    $display("[TB] outstanding limit");
    mode2 = 8'd0;
    start2 = 1'b1;
    @(posedge clk); @(negedge clk);
    start2 = 1'b0;
    cnt2 = 0;
    repeat (8) cyc2(1'b0);
    check_output("lim_first", 32'(cnt2), 32'd2);
    #1;
    check_output("lim_vld_low", 32'(vld2), 32'd0);
    cnt2 = 0;
    cyc2(1'b1);
    repeat (7) cyc2(1'b0);
    check_output("lim_one_more", 32'(cnt2), 32'd1);
    cnt2 = 0;
    cyc2(1'b1);
    repeat (5) cyc2(1'b0);
    check_output("lim_last_s0", 32'(cnt2), 32'd1);
    cnt2 = 0;
    cyc2(1'b1);
    repeat (5) cyc2(1'b0);
    check_output("lim_drain_hold", 32'(cnt2), 32'd0);
    #1;
    check_output("lim_drain_stage", 32'(stg2), 32'd0);
    cyc2(1'b1);
    #1;
    check_output("lim_s1_issue", 32'({vld2, stg2, a2, b2}), 32'({1'b1, 3'd1, 3'd0, 3'd2}));
    abort2 = 1'b1;
    @(posedge clk); @(negedge clk);
    abort2 = 1'b0;
    #1;
    check_output("lim_abort_idle", 32'(busy2), 32'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ntt_bfly_sched.md
Name: ntt_bfly_sched

Overview:
- Sequences one full in-place N-point NTT or INTT over the shared butterfly pipeline.
- Per stage, generates the butterfly operand address pair (a, b) and the twiddle index, and issues them over a valid/ready port.
- Tracks butterflies in flight and holds each stage boundary until write-back drains (in-place RAW hazard).
- Sits between the kernel's mode/decode register and the butterfly PE array plus coefficient memory.

Parameters:
- LOG_N, 8, log2 of transform size N (N=256); legal range 2..12.
- MAX_OUT, 4, maximum butterflies issued but not yet completed; must be ≥1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done
- mode  in  8  bit0: 0=forward (CT), 1=inverse (GS); other bits reserved, ignored
- busy  out  1  high from the cycle after start acceptance until return to IDLE
- done  out  1  one-cycle pulse when the final stage has drained
- err  out  1  sticky: cmp_vld seen with zero outstanding; cleared on start acceptance
- iss_vld  out  1  butterfly issue valid
- iss_rdy  in  1  butterfly array ready
- iss_addr_a  out  LOG_N  top operand address
- iss_addr_b  out  LOG_N  bottom operand address
- iss_tw  out  LOG_N  twiddle ROM index
- iss_stage  out  clog2(LOG_N)+1  current stage s
- iss_inv  out  1  latched mode bit0
- iss_lst  out  1  marks the last butterfly of the current stage
- cmp_vld  in  1  one butterfly write-back completed (pulse per completion)

Behaviour:
- Reset values: state=IDLE; busy, done, err, iss_vld, iss_lst, iss_inv = 0; addresses, tw, stage, counters = 0.
- Counters: stage s ∈ 0..LOG_N-1; butterfly index i ∈ 0..N/2-1; outstanding o ∈ 0..MAX_OUT.
- Forward: len = N>>(s+1). Inverse: len = 1<<s.
- Addressing: j = i mod len; k = i / len; a = k·2·len + j; b = a + len.
- Twiddle index: forward tw = (1<<s) + k; inverse tw = (N>>(s+1)) + k.
- All values fit in LOG_N bits with no wrap. Outputs derive only from registered state and are stable while iss_vld=1 and iss_rdy=0.
- Issue handshake: transfer when iss_vld && iss_rdy. iss_vld = (state==ISSUE) && (o < MAX_OUT). iss_vld never depends on iss_rdy.
- Outstanding count o: +1 on transfer, −1 on cmp_vld. On a simultaneous transfer and cmp_vld, o is unchanged. If cmp_vld arrives with o=0, set err and leave o at 0.
- FSM IDLE: start → latch mode bit0, clear s, i, err → ISSUE. iss_vld rises the cycle after start.
- FSM ISSUE: on transfer, i++. On the transfer with i = N/2-1 (iss_lst=1), clear i → DRAIN.
- FSM DRAIN: no issue. Leave when next o == 0, counting a same-cycle cmp_vld.
  - If s = LOG_N-1 → FINISH.
  - Otherwise s++ → ISSUE on the following cycle.
- FSM FINISH: done=1 for one cycle, busy=0 → IDLE.
- Minimum stage turnaround (zero-latency completion) is 1 dead cycle.
- start while busy is ignored; the mode port is ignored after latching.
- abort in any state → IDLE next cycle; o cleared, no done pulse, err kept. abort has priority over start and over a handshake in the same cycle; that transfer is dropped and not counted.
- rstn asserted mid-operation: immediate return to reset values; late cmp_vld pulses after reset set err.
- Total issues per transform: (N/2)·LOG_N.

Test Plan:
- LOG_N=3, MAX_OUT=4, forward, iss_rdy=1, cmp_vld 2 cycles after each issue. Required stream (a,b,tw):
  - s0: (0,4,1) (1,5,1) (2,6,1) (3,7,1)
  - s1: (0,2,2) (1,3,2) (4,6,3) (5,7,3)
  - s2: (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - Then done pulses exactly once, and 12 issues total.
- Same setup, inverse. Required tw sequence: s0 4,5,6,7; s1 2,2,3,3 (pairs (0,2)(1,3)(4,6)(5,7)); s2 1,1,1,1 (pairs (0,4)…(3,7)).
- MAX_OUT=2, cmp_vld withheld: exactly 2 issues then iss_vld=0. One cmp_vld → exactly one more issue. No stage-1 issue before o returns to 0.
- iss_rdy toggled randomly with backpressure: a, b, tw, iss_lst held constant while iss_vld && !iss_rdy. The address sequence is identical to scenario 1.
- abort asserted mid-stage 1, with a handshake in the same cycle: IDLE next cycle, busy=0, done never pulses, o=0. A new start gives a clean stage-0 sequence.
- cmp_vld pulse while idle: err=1 and stays set; next start clears err to 0. start during busy: no effect on the sequence.
